// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default operand width and the matching iteration-counter width.
package div_seq_ctrl_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_seq_ctrl_iter_step.sv
// One combinational non-restoring division step on the {A,Q} pair.
// A carries one extra bit so its sign selects add-back or subtract.
module div_iter_step
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] m_ext;

    // shift {A,Q} left, then add or subtract M depending on the pre-shift sign of A
    always_comb begin
        a_sh   = {a[WIDTH-1:0], q[WIDTH-1]};
        m_ext  = {1'b0, m};
        a_next = a[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
        q_next = {q[WIDTH-2:0], ~a_next[WIDTH]};
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed divider with start/busy/done sequencing.
// Truncating division: quotient rounds toward zero, remainder follows the
// dividend's sign. Divide by zero returns all-ones / dividend and a flag.
//
// state | meaning
// IDLE  | waiting for start, results held
// SETUP | take magnitudes and signs, trap zero divisor
// ITER  | one non-restoring step per cycle, WIDTH steps
// FIX   | restore remainder, apply signs, publish results
// DONE  | one-cycle done pulse
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] dvd_cap;
    logic [WIDTH-1:0] dvs_cap;
    logic [WIDTH-1:0] rem_mag;
    logic             neg_q;
    logic             neg_r;

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .a      (a),
        .q      (q),
        .m      (m),
        .a_next (a_next),
        .q_next (q_next)
    );

    // final remainder restore; only the low WIDTH bits matter after the add-back
    always_comb begin
        rem_mag = a[WIDTH] ? (a[WIDTH-1:0] + m) : a[WIDTH-1:0];
    end

    // controller, datapath registers and registered outputs
    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= S_IDLE;
            cnt         <= '0;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            dvd_cap     <= '0;
            dvs_cap     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_cap <= dividend;
                        dvs_cap <= divisor;
                        busy    <= 1'b1;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    neg_q <= dvd_cap[WIDTH-1] ^ dvs_cap[WIDTH-1];
                    neg_r <= dvd_cap[WIDTH-1];
                    q     <= dvd_cap[WIDTH-1] ? -dvd_cap : dvd_cap;
                    m     <= dvs_cap[WIDTH-1] ? -dvs_cap : dvs_cap;
                    a     <= '0;
                    cnt   <= '0;
                    if (dvs_cap == '0) begin
                        quotient    <= '1;
                        remainder   <= dvd_cap;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    a   <= a_next;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient    <= neg_q ? -q : q;
                    remainder   <= neg_r ? -rem_mag : rem_mag;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl plus a standalone check of div_iter_step.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic         clock;
    logic         clear;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    logic [W:0]   st_a;
    logic [W-1:0] st_q;
    logic [W-1:0] st_m;
    logic [W:0]   st_a_next;
    logic [W-1:0] st_q_next;

    int n_cmp;
    int n_err;

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    div_iter_step #(.WIDTH(W)) u_step_ut (
        .a      (st_a),
        .q      (st_q),
        .m      (st_m),
        .a_next (st_a_next),
        .q_next (st_q_next)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive a start pulse from a negedge so it is sampled at "edge 0".
    task automatic issue_start(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Count cycles after edge 0 until done; busy_bad flags any cycle up to
    // done where busy was low. restart re-pulses start at cycles 10 and 35.
    task automatic wait_done(input bit restart, output int lat, output int busy_bad);
        int cyc;
        cyc = 0;
        lat = -1;
        busy_bad = 0;
        while (lat < 0 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) lat = cyc;
            if (restart) begin
                if (cyc == 10 || cyc == 35) begin
                    start    = 1'b1;
                    dividend = 32'd50;
                    divisor  = 32'd5;
                end else begin
                    start = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset;
        clear = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (quotient !== 32'h0) begin n_err++; $display("FAIL reset_quot got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'h0) begin n_err++; $display("FAIL reset_rem got %h want 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    endtask

    task automatic test_iter_step;
        st_a = 33'h0_0000_0000; st_q = 32'h8000_0000; st_m = 32'd1;
        #1;
        n_cmp++; if (st_a_next !== 33'h0_0000_0000) begin n_err++; $display("FAIL step1_a got %h want 000000000", st_a_next); end
        n_cmp++; if (st_q_next !== 32'h0000_0001) begin n_err++; $display("FAIL step1_q got %h want 00000001", st_q_next); end
        st_a = 33'h1_FFFF_FFFF; st_q = 32'h0; st_m = 32'd3;
        #1;
        n_cmp++; if (st_a_next !== 33'h0_0000_0001) begin n_err++; $display("FAIL step2_a got %h want 000000001", st_a_next); end
        n_cmp++; if (st_q_next !== 32'h0000_0001) begin n_err++; $display("FAIL step2_q got %h want 00000001", st_q_next); end
        st_a = 33'h0_0000_0002; st_q = 32'h0; st_m = 32'd7;
        #1;
        n_cmp++; if (st_a_next !== 33'h1_FFFF_FFFD) begin n_err++; $display("FAIL step3_a got %h want 1fffffffd", st_a_next); end
        n_cmp++; if (st_q_next !== 32'h0000_0000) begin n_err++; $display("FAIL step3_q got %h want 00000000", st_q_next); end
    endtask

    task automatic test_basic;
        int lat, bb;
        issue_start(32'd100, 32'd7);
        wait_done(1'b0, lat, bb);
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL basic_latency got %0d want 35", lat); end
        n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL basic_busy low_cycles got %0d want 0", bb); end
        n_cmp++; if (quotient !== 32'd14) begin n_err++; $display("FAIL basic_quot got %h want 0000000e", quotient); end
        n_cmp++; if (remainder !== 32'd2) begin n_err++; $display("FAIL basic_rem got %h want 00000002", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL basic_after busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_signs;
        logic [W-1:0] vec_dvd [3];
        logic [W-1:0] vec_dvs [3];
        logic [W-1:0] vec_q   [3];
        logic [W-1:0] vec_r   [3];
        int lat, bb;
        vec_dvd[0] = 32'hFFFF_FF9C; vec_dvs[0] = 32'd7;         vec_q[0] = 32'hFFFF_FFF2; vec_r[0] = 32'hFFFF_FFFE;
        vec_dvd[1] = 32'd100;       vec_dvs[1] = 32'hFFFF_FFF9; vec_q[1] = 32'hFFFF_FFF2; vec_r[1] = 32'd2;
        vec_dvd[2] = 32'hFFFF_FF9C; vec_dvs[2] = 32'hFFFF_FFF9; vec_q[2] = 32'd14;        vec_r[2] = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            issue_start(vec_dvd[i], vec_dvs[i]);
            wait_done(1'b0, lat, bb);
            n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL signs%0d_latency got %0d want 35", i, lat); end
            n_cmp++; if (quotient !== vec_q[i]) begin n_err++; $display("FAIL signs%0d_quot got %h want %h", i, quotient, vec_q[i]); end
            n_cmp++; if (remainder !== vec_r[i]) begin n_err++; $display("FAIL signs%0d_rem got %h want %h", i, remainder, vec_r[i]); end
            @(negedge clock);
        end
    endtask

    task automatic test_overflow;
        int lat, bb;
        issue_start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, lat, bb);
        n_cmp++; if (quotient !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_quot got %h want 80000000", quotient); end
        n_cmp++; if (remainder !== 32'h0) begin n_err++; $display("FAIL ovf_rem got %h want 00000000", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL ovf_dbz got %b want 0", div_by_zero); end
        @(negedge clock);
        issue_start(32'h8000_0000, 32'd1);
        wait_done(1'b0, lat, bb);
        n_cmp++; if (quotient !== 32'h8000_0000) begin n_err++; $display("FAIL min_by_one_quot got %h want 80000000", quotient); end
        n_cmp++; if (remainder !== 32'h0) begin n_err++; $display("FAIL min_by_one_rem got %h want 00000000", remainder); end
        @(negedge clock);
    endtask

    task automatic test_div_zero;
        int lat, bb;
        issue_start(32'd5, 32'd0);
        wait_done(1'b0, lat, bb);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL dz_latency got %0d want 2", lat); end
        n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL dz_busy low_cycles got %0d want 0", bb); end
        n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_quot got %h want ffffffff", quotient); end
        n_cmp++; if (remainder !== 32'd5) begin n_err++; $display("FAIL dz_rem got %h want 00000005", remainder); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dz_busy_after got %b want 0", busy); end
        issue_start(32'd9, 32'd3);
        wait_done(1'b0, lat, bb);
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL dz_next_latency got %0d want 35", lat); end
        n_cmp++; if (quotient !== 32'd3) begin n_err++; $display("FAIL dz_next_quot got %h want 00000003", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_err++; $display("FAIL dz_next_rem got %h want 00000000", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_next_flag got %b want 0", div_by_zero); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int lat, bb, hold_bad;
        issue_start(32'd100, 32'd7);
        wait_done(1'b1, lat, bb);
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL restart_latency got %0d want 35", lat); end
        n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL restart_busy low_cycles got %0d want 0", bb); end
        n_cmp++; if (quotient !== 32'd14) begin n_err++; $display("FAIL restart_quot got %h want 0000000e", quotient); end
        n_cmp++; if (remainder !== 32'd2) begin n_err++; $display("FAIL restart_rem got %h want 00000002", remainder); end
        @(negedge clock);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL restart_ignored busy got %b want 0", busy); end
        hold_bad = 0;
        repeat (6) begin
            @(negedge clock);
            if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) hold_bad++;
        end
        n_cmp++; if (hold_bad !== 0) begin n_err++; $display("FAIL restart_hold bad_cycles got %0d want 0", hold_bad); end
    endtask

    task automatic test_clear_mid;
        int lat, bb, cyc, done_seen;
        issue_start(32'd100, 32'd7);
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL clr_done got %b want 0", done); end
        n_cmp++; if (quotient !== 32'h0 || remainder !== 32'h0) begin n_err++; $display("FAIL clr_results got %h/%h want 0/0", quotient, remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL clr_dbz got %b want 0", div_by_zero); end
        done_seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL clr_quiet active_cycles got %0d want 0", done_seen); end
        issue_start(32'd1000, 32'd10);
        wait_done(1'b0, lat, bb);
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL clr_next_latency got %0d want 35", lat); end
        n_cmp++; if (quotient !== 32'd100) begin n_err++; $display("FAIL clr_next_quot got %h want 00000064", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_err++; $display("FAIL clr_next_rem got %h want 00000000", remainder); end
        @(negedge clock);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_iter_step();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_back_to_back();
        test_clear_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
